axis_upsizer: RTL and testbench
===============================

Name: axis_upsizer

Overview:
- Parametrised narrow-to-wide AXI-Stream width converter; successor to the fixed 8-to-32 packer.
- Packs RATIO input beats of IN_W bits into one OUT_W = IN_W*RATIO word.
- Adds full input backpressure (s_axis_tready), selectable lane order, tkeep for partial final words and a packet counter.
- Sits between the byte-wide UDP payload path and 32/64-bit AXI-Stream consumers.

Parameters:
- IN_W, 8, input beat width in bits (>=1).
- RATIO, 4, input beats per output word (>=2).
- MSB_FIRST, 1, 1: the first beat goes to the top lane; 0: the first beat goes to the bottom lane.
- CNT_W, 16, width of the packet counter.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous reset, active-high
- s_axis_tdata  in  IN_W  input beat
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  last beat of packet
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  IN_W*RATIO  packed word
- m_axis_tkeep  out  RATIO  lane valid; bit j qualifies tdata[j*IN_W +: IN_W]
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last word of packet
- m_axis_tready  in  1  downstream ready
- pkt_cnt  out  CNT_W  packets emitted (output tlast handshakes)

Behaviour:
- Single clock domain (aclk). Reset is synchronous and active-high; all state is cleared on any edge where areset=1.
- Reset values:
  - m_axis_tvalid, m_axis_tlast, m_axis_tdata and m_axis_tkeep are 0.
  - pkt_cnt is 0.
  - Fill counter is 0 and the pending flag is 0.
  - s_axis_tready is 1 on the first cycle after reset.
- Structure: assembly register (data, keep, last) + fill counter cnt (0..RATIO-1) + pending flag + output register.
- Lane mapping: beat index i (0-based within a word) goes to lane L.
  - MSB_FIRST=1: L = RATIO-1-i.
  - MSB_FIRST=0: L = i.
  - Unfilled lanes in tdata are 0 and the matching tkeep bits are 0.
- s_axis_tready = !pending. It is combinational from the registered flag, with no path from m_axis_tready.
- Output slot free condition: "free" = !m_axis_tvalid || m_axis_tready.
- On an input handshake:
  - Write the beat into lane L and set keep[L].
  - The word is complete if cnt==RATIO-1 or s_axis_tlast=1. Then cnt<=0.
  - If complete and free: load the output register with the assembled data, keep and last this edge; clear the assembly keep/data.
  - If complete and not free: pending<=1 and hold the assembly register.
  - If not complete: cnt<=cnt+1.
- When pending and free: load the output register from the assembly register, pending<=0, clear the assembly register.
- Output handshake (tvalid && tready) with no load on the same edge: m_axis_tvalid<=0 and m_axis_tlast<=0.
- Latency: a word is valid on m_axis the cycle after its final input beat is accepted.
- Throughput: with m_axis_tready held high, 1 input beat per cycle is sustained indefinitely with no bubbles.
- Backpressure: at most RATIO*2 beats are absorbed while m_axis_tready is low (one word in the output register, one pending); s_axis_tready then stays low.
- m_axis_tdata, tkeep and tlast are stable while tvalid=1 and tready=0 (AXI-Stream rule).
- tlast on beat RATIO-1 gives a full word with tlast=1 and no extra word.
- A tlast on any beat closes the word early and the next packet starts at lane i=0.
- pkt_cnt increments on every output handshake with m_axis_tlast=1 and wraps modulo 2^CNT_W.
- Reset mid-packet discards any partial, pending or output word. No stale lanes leak into the next packet.
- Counter widths: cnt is $clog2(RATIO) bits. RATIO need not be a power of two; cnt wraps explicitly at RATIO-1.

Test Plan:
- IN_W=8, RATIO=4, MSB_FIRST=1; bytes 01..08 with tlast on 08; m_tready=1 -> 0x01020304 keep F last 0, then 0x05060708 keep F last 1; each valid 1 cycle after the 4th/8th beat; pkt_cnt=1.
- 6-byte packet AA BB CC DD EE FF -> 0xAABBCCDD keep F last 0, then 0xEEFF0000 keep 0xC last 1.
- 1-byte packet 5A with tlast -> 0x5A000000 keep 0x8 last 1. The next packet 01..04 gives 0x01020304 (lane 0 restart).
- m_tready=0 for 20 cycles with 12 bytes offered back-to-back -> exactly 8 accepted, then s_tready=0. Output tdata stays 0x01020304, stable. On release -> three words in order, no loss or duplication.
- MSB_FIRST=0 instance; bytes 01 02 03 04 05 with tlast on 05 -> 0x04030201 keep F, then 0x00000005 keep 0x1 last 1.
- areset pulsed after 2 bytes of a packet -> tvalid=0 and pkt_cnt=0; the next packet 11..14 with tlast gives 0x11121314 keep F last 1.

Source files
------------

// File: rtl/axis_upsizer_if.sv
// Stream bundles for the narrow-to-wide upsizer: a narrow input side without
// lane qualifiers and a wide output side that carries tkeep.
interface axis_upsizer_in_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

interface axis_upsizer_out_if #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) ();
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tkeep, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/axis_upsizer.sv
// Packs RATIO narrow AXI-Stream beats into one wide word with tkeep, early
// close on tlast, a one-word skid (pending) slot and a packet counter.
module axis_upsizer #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    axis_upsizer_in_if.slave     s_axis,
    axis_upsizer_out_if.master   m_axis,
    output logic [CNT_W-1:0]     pkt_cnt
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

    logic [CW-1:0]    cnt_q;
    logic             pend_q;
    logic [OUT_W-1:0] asm_data_q;
    logic [RATIO-1:0] asm_keep_q;
    logic             asm_last_q;
    logic [OUT_W-1:0] out_data_q;
    logic [RATIO-1:0] out_keep_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [CNT_W-1:0] pkt_q;

    logic [OUT_W-1:0] asm_data_d;
    logic [RATIO-1:0] asm_keep_d;
    logic [CW-1:0]    lane_s;
    logic             in_hs_s;
    logic             free_s;
    logic             done_s;

    // Handshake qualifiers; ready depends only on the registered pending flag.
    always_comb begin
        in_hs_s = s_axis.tvalid && !pend_q;
        free_s  = !out_valid_q || m_axis.tready;
        done_s  = in_hs_s && ((cnt_q == LAST_IDX) || s_axis.tlast);
        if (MSB_FIRST) begin
            lane_s = LAST_IDX - cnt_q;
        end else begin
            lane_s = cnt_q;
        end
    end

    // Assembly word with the incoming beat merged into its lane.
    always_comb begin
        asm_data_d = asm_data_q;
        asm_keep_d = asm_keep_q;
        for (int j = 0; j < RATIO; j++) begin
            if (CW'(j) == lane_s) begin
                asm_data_d[j*IN_W +: IN_W] = s_axis.tdata;
                asm_keep_d[j]              = 1'b1;
            end else begin
                asm_data_d[j*IN_W +: IN_W] = asm_data_q[j*IN_W +: IN_W];
                asm_keep_d[j]              = asm_keep_q[j];
            end
        end
    end

    // Packing, pending slot, output register and packet counter.
    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            asm_data_q  <= '0;
            asm_keep_q  <= '0;
            asm_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            pkt_q       <= '0;
        end else begin
            if (out_valid_q && m_axis.tready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                if (out_last_q) begin
                    pkt_q <= pkt_q + CNT_W'(1);
                end
            end
            // A pending word has priority; input is stalled while it exists.
            if (pend_q && free_s) begin
                out_data_q  <= asm_data_q;
                out_keep_q  <= asm_keep_q;
                out_last_q  <= asm_last_q;
                out_valid_q <= 1'b1;
                pend_q      <= 1'b0;
                asm_data_q  <= '0;
                asm_keep_q  <= '0;
                asm_last_q  <= 1'b0;
            end else if (in_hs_s) begin
                if (done_s) begin
                    cnt_q <= '0;
                    if (free_s) begin
                        out_data_q  <= asm_data_d;
                        out_keep_q  <= asm_keep_d;
                        out_last_q  <= s_axis.tlast;
                        out_valid_q <= 1'b1;
                        asm_data_q  <= '0;
                        asm_keep_q  <= '0;
                        asm_last_q  <= 1'b0;
                    end else begin
                        asm_data_q <= asm_data_d;
                        asm_keep_q <= asm_keep_d;
                        asm_last_q <= s_axis.tlast;
                        pend_q     <= 1'b1;
                    end
                end else begin
                    asm_data_q <= asm_data_d;
                    asm_keep_q <= asm_keep_d;
                    cnt_q      <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign s_axis.tready = !pend_q;
    assign m_axis.tdata  = out_data_q;
    assign m_axis.tkeep  = out_keep_q;
    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tlast  = out_last_q;
    assign pkt_cnt       = pkt_q;
endmodule

// File: tb/tb_axis_upsizer.sv
// Directed bench for axis_upsizer: MSB-first and LSB-first instances, words
// predicted by a lane model into per-instance queues and checked on handshake.
module tb_axis_upsizer;
    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    axis_upsizer_in_if  #(.DATA_W(8))               s_m ();
    axis_upsizer_in_if  #(.DATA_W(8))               s_l ();
    axis_upsizer_out_if #(.DATA_W(32), .KEEP_W(4))  m_m ();
    axis_upsizer_out_if #(.DATA_W(32), .KEEP_W(4))  m_l ();
    logic [15:0] pkt_m;
    logic [15:0] pkt_l;

    axis_upsizer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b1), .CNT_W(16)) dut_m (
        .aclk(aclk), .areset(areset), .s_axis(s_m), .m_axis(m_m), .pkt_cnt(pkt_m));
    axis_upsizer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b0), .CNT_W(16)) dut_l (
        .aclk(aclk), .areset(areset), .s_axis(s_l), .m_axis(m_l), .pkt_cnt(pkt_l));

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int exp_pkt_m = 0;
    int exp_pkt_l = 0;
    logic [36:0] q_m[$];
    logic [36:0] q_l[$];
    logic [36:0] w_m;
    logic [36:0] w_l;
    logic [31:0] md[2];
    logic [3:0]  mk[2];
    int          mi[2];

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_clear(input bit sel);
        md[sel] = 32'h0;
        mk[sel] = 4'h0;
        mi[sel] = 0;
    endtask

    // sel=0: MSB-first instance, sel=1: LSB-first instance
    task automatic model_accept(input bit sel, input logic [7:0] d, input bit lst);
        int lane;
        lane = sel ? mi[sel] : 3 - mi[sel];
        md[sel][lane*8 +: 8] = d;
        mk[sel][lane] = 1'b1;
        if (mi[sel] == 3 || lst) begin
            if (sel) q_l.push_back({lst, mk[sel], md[sel]});
            else     q_m.push_back({lst, mk[sel], md[sel]});
            model_clear(sel);
        end else begin
            mi[sel]++;
        end
    endtask

    task automatic drive(input bit sel, input logic [7:0] d, input bit lst, input bit vld);
        if (sel) begin
            s_l.tdata = d; s_l.tlast = lst; s_l.tvalid = vld;
        end else begin
            s_m.tdata = d; s_m.tlast = lst; s_m.tvalid = vld;
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit lst);
        bit acc;
        acc = 1'b0;
        drive(sel, d, lst, 1'b1);
        for (int t = 0; t < 50 && !acc; t++) begin
            acc = sel ? s_l.tready : s_m.tready;
            @(posedge aclk); #1;
        end
        check("send_accept", 64'(acc), 64'd1);
        if (acc) model_accept(sel, d, lst);
        drive(sel, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && (q_m.size() != 0 || q_l.size() != 0); t++) begin
            @(posedge aclk); #1;
        end
        check("drain_empty", 64'(q_m.size() + q_l.size()), 64'd0);
    endtask

    always @(negedge aclk) begin
        if (!areset && m_m.tvalid && m_m.tready) begin
            check("m_word_expected", 64'(q_m.size() != 0), 64'd1);
            if (q_m.size() != 0) begin
                w_m = q_m.pop_front();
                check("m_word", {27'd0, m_m.tlast, m_m.tkeep, m_m.tdata}, {27'd0, w_m});
                if (m_m.tlast) exp_pkt_m++;
            end
        end
    end

    always @(negedge aclk) begin
        if (!areset && m_l.tvalid && m_l.tready) begin
            check("l_word_expected", 64'(q_l.size() != 0), 64'd1);
            if (q_l.size() != 0) begin
                w_l = q_l.pop_front();
                check("l_word", {27'd0, m_l.tlast, m_l.tkeep, m_l.tdata}, {27'd0, w_l});
                if (m_l.tlast) exp_pkt_l++;
            end
        end
    end

    initial begin
        int c0;
        int k;
        bit acc;
        logic [7:0] p2[6];
        p2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        model_clear(1'b0);
        model_clear(1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        m_m.tready = 1'b1;
        m_l.tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;

        check("rst_tvalid", 64'(m_m.tvalid), 64'd0);
        check("rst_tdata",  64'(m_m.tdata),  64'd0);
        check("rst_tkeep",  64'(m_m.tkeep),  64'd0);
        check("rst_tlast",  64'(m_m.tlast),  64'd0);
        check("rst_pkt",    64'(pkt_m),      64'd0);
        check("rst_sready", 64'(s_m.tready), 64'd1);
        check("rst_l_tvalid", 64'(m_l.tvalid), 64'd0);

        // Two full words, one beat per cycle
        c0 = cyc;
        for (int i = 1; i <= 8; i++) begin
            send(1'b0, 8'(i), i == 8);
            if (i == 4) begin
                check("t1_w0_valid", 64'(m_m.tvalid), 64'd1);
                check("t1_w0_data",  64'(m_m.tdata),  64'h01020304);
                check("t1_w0_last",  64'(m_m.tlast),  64'd0);
            end
        end
        check("t1_w1_valid", 64'(m_m.tvalid), 64'd1);
        check("t1_w1_data",  64'(m_m.tdata),  64'h05060708);
        check("t1_w1_keep",  64'(m_m.tkeep),  64'hF);
        check("t1_w1_last",  64'(m_m.tlast),  64'd1);
        check("t1_no_bubble", 64'(cyc - c0), 64'd8);
        @(posedge aclk); #1;
        check("t1_idle",  64'(m_m.tvalid), 64'd0);
        check("t1_pkt",   64'(pkt_m),      64'd1);
        check("t1_pkt_model", 64'(pkt_m), 64'(exp_pkt_m));

        // 6-byte packet: partial final word
        for (int i = 0; i < 6; i++) send(1'b0, p2[i], i == 5);
        check("t2_data", 64'(m_m.tdata), 64'hEEFF0000);
        check("t2_keep", 64'(m_m.tkeep), 64'hC);
        check("t2_last", 64'(m_m.tlast), 64'd1);

        // 1-byte packet then lane-0 restart
        send(1'b0, 8'h5A, 1'b1);
        check("t3_data", 64'(m_m.tdata), 64'h5A000000);
        check("t3_keep", 64'(m_m.tkeep), 64'h8);
        check("t3_last", 64'(m_m.tlast), 64'd1);
        for (int i = 1; i <= 4; i++) send(1'b0, 8'(i), i == 4);
        check("t3_restart", 64'(m_m.tdata), 64'h01020304);
        @(posedge aclk); #1;
        check("t3_pkt", 64'(pkt_m), 64'd4);

        // Downstream stalled: 12 bytes offered, two words absorbed
        m_m.tready = 1'b0;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            acc = s_m.tready;
            drive(1'b0, 8'(k + 1), k == 11, 1'b1);
            @(posedge aclk); #1;
            if (acc) begin
                model_accept(1'b0, 8'(k + 1), k == 11);
                k++;
            end
            if (c == 10) check("t4_stable_mid", 64'(m_m.tdata), 64'h01020304);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("t4_accepted", 64'(k), 64'd8);
        check("t4_sready",   64'(s_m.tready), 64'd0);
        check("t4_valid",    64'(m_m.tvalid), 64'd1);
        check("t4_stable",   64'(m_m.tdata),  64'h01020304);
        m_m.tready = 1'b1;
        for (int i = 8; i < 12; i++) send(1'b0, 8'(i + 1), i == 11);
        drain();
        check("t4_pkt", 64'(pkt_m), 64'd5);

        // LSB-first instance
        for (int i = 1; i <= 5; i++) begin
            send(1'b1, 8'(i), i == 5);
            if (i == 4) check("t5_w0_data", 64'(m_l.tdata), 64'h04030201);
        end
        check("t5_w1_data", 64'(m_l.tdata), 64'h00000005);
        check("t5_w1_keep", 64'(m_l.tkeep), 64'h1);
        check("t5_w1_last", 64'(m_l.tlast), 64'd1);
        @(posedge aclk); #1;
        check("t5_pkt", 64'(pkt_l), 64'd1);

        // Reset mid-packet
        send(1'b0, 8'hE1, 1'b0);
        send(1'b0, 8'hE2, 1'b0);
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        model_clear(1'b0);
        model_clear(1'b1);
        q_m.delete();
        q_l.delete();
        exp_pkt_m = 0;
        exp_pkt_l = 0;
        check("t6_valid",  64'(m_m.tvalid), 64'd0);
        check("t6_pkt",    64'(pkt_m),      64'd0);
        check("t6_pkt_l",  64'(pkt_l),      64'd0);
        check("t6_sready", 64'(s_m.tready), 64'd1);
        for (int i = 0; i < 4; i++) send(1'b0, 8'(8'h11 + i), i == 3);
        check("t6_data", 64'(m_m.tdata), 64'h11121314);
        check("t6_keep", 64'(m_m.tkeep), 64'hF);
        check("t6_last", 64'(m_m.tlast), 64'd1);
        drain();
        check("t6_pkt_after", 64'(pkt_m), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
